// File: rtl/space_pkg.sv
// Shared definitions for the enemy formation blocks: march FSM states and screen constants.
package space_pkg;

    localparam int unsigned COORD_W    = 11;
    localparam int unsigned FRAME_LINE = 400;
    localparam int unsigned PERIOD_W   = 8;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STEP   = 2'd1,
        ST_LANDED = 2'd2
    } march_state_e;

endpackage

// File: rtl/march_period_ctr.sv
// Frame counter and step-period register for the enemy march; emits a one-cycle period_done.
// MARCH_ACCEL_EN: kill shortens the period down to PERIOD_MIN; otherwise the period is fixed.
module march_period_ctr
    import space_pkg::*;
#(
    parameter int unsigned PERIOD_INIT = 30,
    parameter int unsigned PERIOD_MIN  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic frame_tick,
    input  logic kill,
    input  logic restart,
    output logic period_done
);

    localparam logic [PERIOD_W-1:0] PER_INIT = PERIOD_W'(PERIOD_INIT);

    logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, cnt_inc_c;
    logic                done_q, done_d;

    assign cnt_inc_c = cnt_q + PERIOD_W'(1);

`ifdef MARCH_ACCEL_EN
    localparam logic [PERIOD_W-1:0] PER_MIN = PERIOD_W'(PERIOD_MIN);
    logic [PERIOD_W-1:0] period_d;

    always_comb begin
        period_d = period_q;
        if (restart) begin
            period_d = PER_INIT;
        end else if (kill && (period_q > PER_MIN)) begin
            period_d = period_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q <= PER_INIT;
        end else begin
            period_q <= period_d;
        end
    end
`else
    logic unused_kill;
    assign unused_kill = kill;
    assign period_q    = PER_INIT;
`endif

    // A kill may drop the period below the running count, so ">=" keeps the next tick terminal.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (count_en && frame_tick) begin
            if (cnt_inc_c >= period_q) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_inc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign period_done = done_q;

endmodule

// File: rtl/enemy_march_ctrl.sv
// Enemy formation sequencer: steps X each period, drops and reverses at the edges, flags landing.
// MARCH_ACCEL_EN: kill pulses shorten the step period (see march_period_ctr).
module enemy_march_ctrl
    import space_pkg::*;
#(
    parameter int unsigned X_LEFT      = 16,
    parameter int unsigned X_RIGHT     = 176,
    parameter int unsigned X_STEP      = 4,
    parameter int unsigned Y_TOP       = 32,
    parameter int unsigned Y_STEP      = 16,
    parameter int unsigned Y_LIMIT     = 320,
    parameter int unsigned PERIOD_INIT = 30,
    parameter int unsigned PERIOD_MIN  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               run,
    input  logic               kill,
    input  logic               restart,
    output logic [COORD_W-1:0] form_x,
    output logic [COORD_W-1:0] form_y,
    output logic               dir,
    output logic               step_pulse,
    output logic               anim,
    output logic               landed
);

    localparam logic [COORD_W-1:0] XL = COORD_W'(X_LEFT);
    localparam logic [COORD_W-1:0] XR = COORD_W'(X_RIGHT);
    localparam logic [COORD_W-1:0] XS = COORD_W'(X_STEP);
    localparam logic [COORD_W-1:0] YT = COORD_W'(Y_TOP);
    localparam logic [COORD_W-1:0] YS = COORD_W'(Y_STEP);
    localparam logic [COORD_W-1:0] YL = COORD_W'(Y_LIMIT);

    march_state_e       state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dir_q, dir_d, anim_q, anim_d, step_q, step_d, landed_q, landed_d;
    logic               period_done, at_edge_c;

    march_period_ctr #(
        .PERIOD_INIT (PERIOD_INIT),
        .PERIOD_MIN  (PERIOD_MIN)
    ) u_period (
        .clk         (clk),
        .reset       (reset),
        .count_en    (run && (state_q == ST_WAIT)),
        .frame_tick  (frame_tick),
        .kill        (kill && (state_q != ST_LANDED)),
        .restart     (restart),
        .period_done (period_done)
    );

    // Edge test before the add keeps form_x inside [X_LEFT, X_RIGHT].
    assign at_edge_c = dir_q ? (x_q < (XL + XS)) : ((x_q + XS) > XR);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        anim_d   = anim_q;
        step_d   = 1'b0;
        landed_d = landed_q;
        case (state_q)
            ST_WAIT: begin
                if (period_done) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                step_d = 1'b1;
                anim_d = ~anim_q;
                if (at_edge_c) begin
                    y_d   = y_q + YS;
                    dir_d = ~dir_q;
                end else if (dir_q) begin
                    x_d = x_q - XS;
                end else begin
                    x_d = x_q + XS;
                end
                if (y_d >= YL) begin
                    state_d  = ST_LANDED;
                    landed_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_LANDED: begin
                landed_d = 1'b1;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
        if (restart) begin
            state_d  = ST_WAIT;
            x_d      = XL;
            y_d      = YT;
            dir_d    = 1'b0;
            anim_d   = 1'b0;
            step_d   = 1'b0;
            landed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_WAIT;
            x_q      <= XL;
            y_q      <= YT;
            dir_q    <= 1'b0;
            anim_q   <= 1'b0;
            step_q   <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            anim_q   <= anim_d;
            step_q   <= step_d;
            landed_q <= landed_d;
        end
    end

    assign form_x     = x_q;
    assign form_y     = y_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign anim       = anim_q;
    assign landed     = landed_q;

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// Randomized bench for enemy_march_ctrl against a frame/step-level reference model.
module tb_enemy_march_ctrl;

    localparam int PI   = 5;
    localparam int PMIN = 2;
    localparam int XL = 16, XR = 176, XS = 4, YT = 32, YS = 16, YL = 320;
`ifdef MARCH_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, frame_tick, run, kill, restart;
    logic [10:0] form_x, form_y;
    logic        dir, step_pulse, anim, landed;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_x, m_y, m_cnt, m_period, m_pend;
    bit m_dir, m_anim, m_landed, m_step;

    enemy_march_ctrl #(
        .X_LEFT(XL), .X_RIGHT(XR), .X_STEP(XS), .Y_TOP(YT), .Y_STEP(YS),
        .Y_LIMIT(YL), .PERIOD_INIT(PI), .PERIOD_MIN(PMIN)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .kill(kill),
        .restart(restart), .form_x(form_x), .form_y(form_y), .dir(dir),
        .step_pulse(step_pulse), .anim(anim), .landed(landed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_x = XL; m_y = YT; m_dir = 0; m_anim = 0; m_landed = 0; m_step = 0;
        m_cnt = 0; m_period = PI; m_pend = 0;
    endtask

    // One clock edge of the model; m_pend counts edges until the step becomes visible.
    task automatic model_edge(input bit tk, input bit rn, input bit kl, input bit rs);
        bit landed_old;
        int pend_old;
        if (rs) begin
            model_reset();
            return;
        end
        landed_old = m_landed;
        pend_old   = m_pend;
        m_step     = 0;
        if (tk && rn && !landed_old && pend_old != 1) begin
            m_cnt = m_cnt + 1;
            if (m_cnt >= m_period) begin
                m_cnt  = 0;
                m_pend = 3;
            end
        end
        if (kl && !landed_old && ACCEL && m_period > PMIN) m_period = m_period - 1;
        if (pend_old == 1) begin
            if (m_dir == 0 && m_x + XS > XR || m_dir == 1 && m_x < XL + XS) begin
                m_y = m_y + YS;
                m_dir = ~m_dir;
            end else begin
                m_x = m_dir ? m_x - XS : m_x + XS;
            end
            m_anim = ~m_anim;
            m_step = 1;
            if (m_y >= YL) m_landed = 1;
        end
        if (m_pend > 0) m_pend = m_pend - 1;
    endtask

    function automatic logic [25:0] exp_vec();
        return {11'(m_x), 11'(m_y), m_dir, m_step, m_anim, m_landed};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
    task automatic cyc(input bit tk, input bit rn, input bit kl, input bit rs);
        frame_tick = tk; run = rn; kill = kl; restart = rs;
        @(posedge clk);
        model_edge(tk, rn, kl, rs);
        #1;
        frame_tick = 0; kill = 0; restart = 0;
    endtask

    task automatic test_reset();
        reset = 0; frame_tick = 0; run = 0; kill = 0; restart = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1;
        total++;
        if ({form_x, form_y, dir, step_pulse, anim, landed} !== {11'd16, 11'd32, 4'b0000}) begin
            bad++;
            $display("FAIL reset_values act=%h exp=%h", {form_x, form_y, dir, step_pulse, anim, landed}, {11'd16, 11'd32, 4'b0000});
        end
    endtask

    task automatic test_first_step();
        int tick_no = 0;
        cyc(0, 1, 0, 1);
        for (int c = 0; c < 4 * PI + 6; c++) begin
            bit tk = (c % 4 == 0) && tick_no < PI;
            if (tk) tick_no++;
            cyc(tk, 1, 0, 0);
            total++;
            if ({form_x, form_y, dir, step_pulse, anim, landed} !== exp_vec()) begin
                bad++;
                $display("FAIL first_step c=%0d act=%h exp=%h", c, {form_x, form_y, dir, step_pulse, anim, landed}, exp_vec());
            end
            if (c == 4 * (PI - 1) + 1 || c == 4 * (PI - 1) + 2) begin
                total++;
                if ({step_pulse, form_x, anim} !== {c == 4 * (PI - 1) + 2, 11'(c == 4 * (PI - 1) + 2 ? 20 : 16), c == 4 * (PI - 1) + 2}) begin
                    bad++;
                    $display("FAIL first_step_timing c=%0d act pulse=%0d x=%0d anim=%0d", c, step_pulse, form_x, anim);
                end
            end
        end
    endtask

    task automatic test_edge_turn();
        int phase = 0;
        cyc(0, 1, 0, 1);
        for (int c = 0; c < 3000 && phase < 2; c++) begin
            cyc(c % 3 == 0, 1, 0, 0);
            total++;
            if ({form_x, form_y, dir, step_pulse, anim, landed} !== exp_vec()) begin
                bad++;
                $display("FAIL edge_turn c=%0d act=%h exp=%h", c, {form_x, form_y, dir, step_pulse, anim, landed}, exp_vec());
            end
            if (step_pulse && phase == 1) begin
                phase = 2;
                total++;
                if (form_x !== 11'd172) begin
                    bad++;
                    $display("FAIL edge_after_turn act x=%0d exp x=172", form_x);
                end
            end
            if (step_pulse && dir && phase == 0) begin
                phase = 1;
                total++;
                if ({form_x, form_y} !== {11'd176, 11'd48}) begin
                    bad++;
                    $display("FAIL edge_drop act x=%0d y=%0d exp x=176 y=48", form_x, form_y);
                end
            end
        end
        if (phase != 2) begin
            bad++; total++;
            $display("FAIL edge_turn_timeout act phase=%0d exp phase=2", phase);
        end
    endtask

    task automatic test_land();
        int prev_y = YT;
        bit seen = 0;
        cyc(0, 1, 0, 1);
        for (int c = 0; c < 20000 && !seen; c++) begin
            prev_y = form_y;
            cyc(c % 3 == 0, 1, 0, 0);
            total++;
            if ({form_x, form_y, dir, step_pulse, anim, landed} !== exp_vec()) begin
                bad++;
                $display("FAIL land c=%0d act=%h exp=%h", c, {form_x, form_y, dir, step_pulse, anim, landed}, exp_vec());
            end
            if (landed) begin
                seen = 1;
                total++;
                if (prev_y !== 304 || form_y !== 11'd320 || !step_pulse) begin
                    bad++;
                    $display("FAIL land_edge act prev_y=%0d y=%0d pulse=%0d exp 304 320 1", prev_y, form_y, step_pulse);
                end
            end
        end
        if (!seen) begin
            bad++; total++;
            $display("FAIL land_timeout act landed=0 exp landed=1");
        end
        for (int c = 0; c < 40; c++) begin
            cyc(c % 2 == 0, 1, c % 5 == 0, 0);
            total++;
            if (step_pulse !== 1'b0 || landed !== 1'b1) begin
                bad++;
                $display("FAIL landed_hold c=%0d act pulse=%0d landed=%0d exp 0 1", c, step_pulse, landed);
            end
        end
        cyc(0, 1, 0, 1);
        total++;
        if ({form_x, form_y, dir, step_pulse, anim, landed} !== {11'd16, 11'd32, 4'b0000}) begin
            bad++;
            $display("FAIL restart_values act=%h exp=%h", {form_x, form_y, dir, step_pulse, anim, landed}, {11'd16, 11'd32, 4'b0000});
        end
    endtask

    task automatic test_run_hold();
        int after = 0;
        bit done = 0;
        cyc(0, 1, 0, 1);
        for (int c = 0; c < 8; c++) cyc(c % 4 == 0, 1, 0, 0);
        for (int c = 0; c < 40; c++) begin
            cyc(c % 4 == 0, 0, 0, 0);
            total++;
            if ({form_x, form_y, dir, step_pulse, anim, landed} !== exp_vec()) begin
                bad++;
                $display("FAIL run_hold c=%0d act=%h exp=%h", c, {form_x, form_y, dir, step_pulse, anim, landed}, exp_vec());
            end
        end
        for (int c = 0; c < 100 && !done; c++) begin
            if (c % 4 == 0) after++;
            cyc(c % 4 == 0, 1, 0, 0);
            if (step_pulse) begin
                done = 1;
                total++;
                if (after !== PI - 2) begin
                    bad++;
                    $display("FAIL run_resume act ticks=%0d exp ticks=%0d", after, PI - 2);
                end
            end
        end
        if (!done) begin
            bad++; total++;
            $display("FAIL run_resume_timeout act no step exp step");
        end
    endtask

    task automatic test_accel();
        int want = ACCEL ? PMIN : PI;
        cyc(0, 1, 0, 1);
        for (int k = 0; k < 40; k++) cyc(0, 1, 1, 0);
        for (int rep = 0; rep < 2; rep++) begin
            int ticks = 0;
            bit done = 0;
            for (int c = 0; c < 400 && !done; c++) begin
                if (c % 4 == 0) ticks++;
                cyc(c % 4 == 0, 1, 0, 0);
                if (step_pulse) begin
                    done = 1;
                    total++;
                    if (ticks !== want) begin
                        bad++;
                        $display("FAIL accel_period rep=%0d act ticks=%0d exp ticks=%0d", rep, ticks, want);
                    end
                end
            end
            if (!done) begin
                bad++; total++;
                $display("FAIL accel_timeout rep=%0d act no step exp step", rep);
            end
        end
    endtask

    task automatic test_random();
        cyc(0, 1, 0, 1);
        for (int c = 0; c < 1500; c++) begin
            cyc($urandom_range(2, 0) == 0, $urandom_range(9, 0) != 0,
                $urandom_range(19, 0) == 0, $urandom_range(399, 0) == 0);
            total++;
            if ({form_x, form_y, dir, step_pulse, anim, landed} !== exp_vec()) begin
                bad++;
                $display("FAIL random c=%0d act=%h exp=%h", c, {form_x, form_y, dir, step_pulse, anim, landed}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_in_step();
        bit hit = 0;
        cyc(0, 1, 0, 1);
        for (int c = 0; c < 200 && !hit; c++) begin
            cyc(c % 4 == 0, 1, 0, 0);
            if (m_pend == 1 && form_x == 11'(XL + XS)) hit = 1;
        end
        if (!hit) begin
            bad++; total++;
            $display("FAIL reset_step_reach act no STEP exp STEP");
        end
        #2 reset = 0;
        #1;
        total++;
        if ({form_x, form_y, dir, step_pulse, anim, landed} !== {11'd16, 11'd32, 4'b0000}) begin
            bad++;
            $display("FAIL reset_in_step act=%h exp=%h", {form_x, form_y, dir, step_pulse, anim, landed}, {11'd16, 11'd32, 4'b0000});
        end
        @(posedge clk);
        #1;
        total++;
        if ({form_x, form_y, dir, step_pulse, anim, landed} !== {11'd16, 11'd32, 4'b0000}) begin
            bad++;
            $display("FAIL reset_in_step_hold act=%h exp=%h", {form_x, form_y, dir, step_pulse, anim, landed}, {11'd16, 11'd32, 4'b0000});
        end
        reset = 1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            cyc(0, 1, 0, 0);
            total++;
            if ({form_x, form_y, dir, step_pulse, anim, landed} !== exp_vec()) begin
                bad++;
                $display("FAIL reset_in_step_after c=%0d act=%h exp=%h", c, {form_x, form_y, dir, step_pulse, anim, landed}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_edge_turn();
        test_run_hold();
        test_accel();
        test_random();
        test_reset_in_step();
        test_land();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_march_ctrl.md
# enemy_march_ctrl

Formation sequencer for the enemy rows. It counts frame ticks from the VGA timing and steps the formation's X position sideways at a programmable period. At either screen edge it drops the formation by one row and reverses direction. Its X/Y outputs drive the enemy-row position inputs of the graphics block. The step period optionally shortens as enemies are destroyed.

## Interface
Parameters:
- X_LEFT, 16: minimum formation left-edge X.
- X_RIGHT, 176: maximum formation left-edge X.
- X_STEP, 4: lateral step in pixels.
- Y_TOP, 32: formation Y after reset/restart.
- Y_STEP, 16: drop distance at an edge.
- Y_LIMIT, 320: Y at or beyond which the formation has landed.
- PERIOD_INIT, 30: frames per step after reset/restart.
- PERIOD_MIN, 2: lowest step period.

Ports:
- clk  in  1  system clock, same domain as vga_sync.
- reset  in  1  asynchronous, active-low; all state returns to reset values while low.
- frame_tick  in  1  one-cycle pulse per frame (y==400 strobe).
- run  in  1  level; 0 freezes the frame count and the formation.
- kill  in  1  one-cycle pulse per enemy destroyed.
- restart  in  1  synchronous one-cycle pulse; reload reset values.
- form_x  out  11  formation left-edge X.
- form_y  out  11  formation top Y.
- dir  out  1  0 = moving right, 1 = moving left.
- step_pulse  out  1  high exactly one cycle when form_x or form_y changes.
- anim  out  1  toggles on every step (sprite frame select).
- landed  out  1  sticky; formation reached Y_LIMIT.

## Operation
- Reset/restart values: form_x=X_LEFT, form_y=Y_TOP, dir=0, anim=0, step_pulse=0, landed=0, frame count=0, period=PERIOD_INIT, state=WAIT.
- States:
  - WAIT: on frame_tick with run=1, increment the frame count. If the count equals period-1, clear the count and go to STEP. frame_tick with run=0 is ignored and the count holds.
  - STEP (one cycle):
    - If dir=0 and form_x+X_STEP>X_RIGHT, or dir=1 and form_x<X_LEFT+X_STEP: do an edge drop. form_y+=Y_STEP, dir toggles, form_x unchanged.
    - Otherwise form_x moves by ±X_STEP.
    - anim toggles; step_pulse is asserted.
    - Next state is LANDED if the new form_y>=Y_LIMIT, else WAIT.
  - LANDED: landed=1; frame_tick and kill are ignored. Exit only via reset or restart.
- Period: kill decrements the period by 1, saturating at PERIOD_MIN. The new period is used at the next comparison.
- Arithmetic is 11-bit unsigned. Edge tests are done before the add, so form_x never leaves [X_LEFT, X_RIGHT].
- Simultaneous events:
  - restart beats everything.
  - kill together with the completing frame_tick: the step still occurs this period, and the decrement applies afterward.
  - run deasserted while in STEP: the step completes.

## Timing
- frame_tick that completes the period is sampled at edge N. State is STEP during cycle N+1. New form_x/form_y/dir/anim and step_pulse=1 are visible after edge N+2, for one cycle.
- All outputs are registered; there is no combinational path from input to output.
- restart takes effect at the next edge. Reset is immediate on its falling edge.
- Only one step per completed period. At PERIOD_MIN, at most one step every PERIOD_MIN frames.

## Configuration
- MARCH_ACCEL_EN defined: kill decrements the period as above.
- MARCH_ACCEL_EN undefined: kill is ignored and the period is constant at PERIOD_INIT. The period register reduces to a constant.

## Structure
- Shared package space_pkg holds:
  - march state enum (WAIT, STEP, LANDED);
  - 11-bit screen coordinate width constant;
  - frame-strobe line constant 400.
- One sub-module, march_period_ctr, holds the frame counter, the period register and kill saturation. Its output is a one-cycle "period done" flag to the FSM.

## Test plan
- PERIOD_INIT=3, run=1, 3 frame_ticks → step_pulse 2 cycles after 3rd tick; form_x 16→20, anim=1; no change after ticks 1–2.
- form_x=176, dir=0, period completes → form_y 32→48, dir=1, form_x stays 176; next step form_x=172.
- form_y=304, edge drop → form_y=320, landed=1; further frame_ticks produce no step_pulse; restart → form_x=16, form_y=32, landed=0.
- MARCH_ACCEL_EN, 40 kill pulses from period 30 → period saturates at 2; steps every 2 frames. Without the macro → still every 30 frames.
- run=0 across 10 frame_ticks mid-count → no step, count preserved; run=1 resumes from the held count.
- reset pulled low during STEP → all outputs at reset values immediately; no step_pulse emitted.
